// File: rtl/mac_stall_ctrl_pkg.sv
// mac_stall_ctrl_pkg
// Shared constants and types for the MAC sequencing / stall controller:
//   - reset polarity (ResetEnable)
//   - stall vector bit positions (StallPC..StallWB) and width
//   - double-register bus width (DoubleRegBus)
//   - MAC FSM state type (MacIdle, MacAcc)
package mac_stall_ctrl_pkg;

  localparam logic ResetEnable = 1'b1;

  // Stall vector layout: one bit per pipeline register, PC first.
  localparam int unsigned StallW  = 6;
  localparam int unsigned StallPC = 0;
  localparam int unsigned StallIF = 1;
  localparam int unsigned StallID = 2;
  localparam int unsigned StallEX = 3;
  localparam int unsigned StallMEM = 4;
  localparam int unsigned StallWB = 5;

  // Width of the HI:LO pair / multiplier product for 32-bit registers.
  localparam int unsigned DoubleRegBus = 64;

  typedef enum logic {
    MacIdle = 1'b0,
    MacAcc  = 1'b1
  } mac_state_e;

endpackage

// File: rtl/mac_stall_ctrl_if.sv
// mac_stall_ctrl_if
// Bus between the EX stage and the MAC/stall controller.
//   EX -> ctrl : mac_start, mac_sub, mul_result, hi_in, lo_in, flush,
//                stallreq_id, stallreq_ex_ext
//   ctrl -> EX : mac_valid, mac_hi, mac_lo, stall
// Modports: master (EX-stage side, drives requests), slave (controller).
interface mac_stall_ctrl_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned STALL_W = 6
);

  logic                  mac_start;
  logic                  mac_sub;
  logic [2*DATA_W-1:0]   mul_result;
  logic [DATA_W-1:0]     hi_in;
  logic [DATA_W-1:0]     lo_in;
  logic                  flush;
  logic                  stallreq_id;
  logic                  stallreq_ex_ext;
  logic                  mac_valid;
  logic [DATA_W-1:0]     mac_hi;
  logic [DATA_W-1:0]     mac_lo;
  logic [STALL_W-1:0]    stall;

  modport master (
    output mac_start, mac_sub, mul_result, hi_in, lo_in, flush,
           stallreq_id, stallreq_ex_ext,
    input  mac_valid, mac_hi, mac_lo, stall
  );

  modport slave (
    input  mac_start, mac_sub, mul_result, hi_in, lo_in, flush,
           stallreq_id, stallreq_ex_ext,
    output mac_valid, mac_hi, mac_lo, stall
  );

endinterface

// File: rtl/mac_stall_ctrl_stall_merge.sv
// stall_merge
// Combinational priority encoder producing the global stall vector.
//   flush        in  : kill everything, no stall
//   stallreq_ex  in  : hold PC, IF/ID, ID/EX, EX (vector 6'b001111)
//   stallreq_id  in  : hold PC, IF/ID, ID     (vector 6'b000111)
//   stall        out : STALL_W-bit vector, bit0 PC ... bit5 WB
// Priority: flush > EX > ID.
module stall_merge
  import mac_stall_ctrl_pkg::*;
#(
  parameter int unsigned STALL_W = StallW
) (
  input  logic               flush,
  input  logic               stallreq_ex,
  input  logic               stallreq_id,
  output logic [STALL_W-1:0] stall
);

  always_comb begin
    stall = '0;
    if (!flush) begin
      if (stallreq_ex) begin
        stall[StallPC] = 1'b1;
        stall[StallIF] = 1'b1;
        stall[StallID] = 1'b1;
        stall[StallEX] = 1'b1;
      end else if (stallreq_id) begin
        stall[StallPC] = 1'b1;
        stall[StallIF] = 1'b1;
        stall[StallID] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_stall_ctrl.sv
// mac_stall_ctrl
// Sequencer for two-cycle multiply-accumulate (MADD/MADDU/MSUB/MSUBU) in EX
// and generator of the global stall vector.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : mac_start, mac_sub, mul_result, hi_in, lo_in, flush,
//                  stallreq_id, stallreq_ex_ext in;
//                  mac_valid, mac_hi, mac_lo, stall out
//   stall_cycles : cycles with stall[EX] set (only with MAC_STALL_CNT_EN)
// Cycle 1 (IDLE): product (negated for MSUB) is captured, EX and upstream
// stall. Cycle 2 (ACC): HI:LO + captured product is presented with
// mac_valid; the FSM always returns to IDLE so a still-high mac_start for
// the same instruction does not retrigger.
// Optional feature macro: MAC_STALL_CNT_EN (adds the stall_cycles counter).
module mac_stall_ctrl
  import mac_stall_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned STALL_W = StallW
) (
  input  logic              clk,
  input  logic              rst,
  mac_stall_ctrl_if.slave   bus
`ifdef MAC_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  mac_state_e             state_q, state_d;
  logic [2*DATA_W-1:0]    hilo_temp_q;
  logic [2*DATA_W-1:0]    acc_sum;
  logic                   in_reset;
  logic                   mac_accept;
  logic                   stallreq_mac;
  logic                   stallreq_ex;

  assign in_reset   = (rst == ResetEnable);
  assign mac_accept = (state_q == MacIdle) && bus.mac_start && !bus.flush;
  assign acc_sum    = {bus.hi_in, bus.lo_in} + hilo_temp_q;

  always_comb begin
    state_d      = state_q;
    stallreq_mac = 1'b0;
    bus.mac_valid = 1'b0;
    bus.mac_hi    = '0;
    bus.mac_lo    = '0;
    case (state_q)
      MacIdle: begin
        if (bus.mac_start && !bus.flush) begin
          stallreq_mac = 1'b1;
          state_d      = MacAcc;
        end
      end
      MacAcc: begin
        state_d = MacIdle;
        if (!bus.flush) begin
          bus.mac_valid                = 1'b1;
          {bus.mac_hi, bus.mac_lo} = acc_sum;
        end
      end
      default: state_d = MacIdle;
    endcase
    // Reset overrides the combinational outputs too, so a reset landing in
    // ACC never shows a partial result.
    if (in_reset) begin
      state_d       = MacIdle;
      stallreq_mac  = 1'b0;
      bus.mac_valid = 1'b0;
      bus.mac_hi    = '0;
      bus.mac_lo    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_reset) begin
      state_q     <= MacIdle;
      hilo_temp_q <= '0;
    end else begin
      state_q <= state_d;
      if (mac_accept) begin
        // Two's-complement negate for MSUB so ACC is always an add.
        hilo_temp_q <= bus.mac_sub ? -bus.mul_result : bus.mul_result;
      end else if (state_q == MacAcc && bus.flush) begin
        hilo_temp_q <= '0;
      end
    end
  end

  assign stallreq_ex = stallreq_mac | bus.stallreq_ex_ext;

  // Reset is folded into the flush input so the vector is all-zero during
  // reset, independent of the request inputs.
  stall_merge #(
    .STALL_W (STALL_W)
  ) u_stall_merge (
    .flush       (bus.flush | in_reset),
    .stallreq_ex (stallreq_ex),
    .stallreq_id (bus.stallreq_id),
    .stall       (bus.stall)
  );

`ifdef MAC_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (in_reset) begin
      stall_cnt_q <= '0;
    end else if (bus.stall[StallEX]) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mac_stall_ctrl.sv
// tb_mac_stall_ctrl
// Directed cases followed by randomized traffic, checked against a
// transaction-level model: a queue of pending accumulations (at most one
// entry) plus a stall-priority rule.
module tb_mac_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_stall_ctrl_if #(.DATA_W(32), .STALL_W(6)) bus ();

`ifdef MAC_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  mac_stall_ctrl #(
    .DATA_W  (32),
    .STALL_W (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MAC_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [63:0] pend[$];
  logic [31:0] exp_cnt = 32'd0;
  logic        cnt_known = 1'b0;

  task automatic set_in(input logic start, input logic sub,
                        input logic [63:0] mul, input logic [31:0] hi,
                        input logic [31:0] lo, input logic fl,
                        input logic id, input logic ext);
    bus.mac_start       = start;
    bus.mac_sub         = sub;
    bus.mul_result      = mul;
    bus.hi_in           = hi;
    bus.lo_in           = lo;
    bus.flush           = fl;
    bus.stallreq_id     = id;
    bus.stallreq_ex_ext = ext;
  endtask

  // Let combinational outputs settle mid-cycle (away from posedge).
  task automatic settle();
    #4;
  endtask

  // Compare against the model, then advance one clock and update the model.
  task automatic step();
    logic        busy;
    logic        e_valid;
    logic [63:0] e_sum;
    logic [5:0]  e_stall;
    busy    = (pend.size() != 0);
    e_valid = !rst && busy && !bus.flush;
    e_sum   = busy ? ({bus.hi_in, bus.lo_in} + pend[0]) : 64'd0;
    if (rst || bus.flush)
      e_stall = 6'b000000;
    else if ((!busy && bus.mac_start) || bus.stallreq_ex_ext)
      e_stall = 6'b001111;
    else if (bus.stallreq_id)
      e_stall = 6'b000111;
    else
      e_stall = 6'b000000;

    check_eq("mac_valid", {63'd0, bus.mac_valid}, {63'd0, e_valid});
    check_eq("stall", {58'd0, bus.stall}, {58'd0, e_stall});
    if (e_valid)
      check_eq("hilo", {bus.mac_hi, bus.mac_lo}, e_sum);
    else if (!busy || rst)
      check_eq("hilo_idle", {bus.mac_hi, bus.mac_lo}, 64'd0);
`ifdef MAC_STALL_CNT_EN
    if (cnt_known && !rst)
      check_eq("stall_cycles", {32'd0, stall_cycles}, {32'd0, exp_cnt});
`endif

    @(posedge clk);
    if (rst) begin
      pend.delete();
      exp_cnt   = 32'd0;
      cnt_known = 1'b1;
    end else begin
      if (e_stall[3]) exp_cnt = exp_cnt + 32'd1;
      if (busy)
        void'(pend.pop_front());
      else if (bus.mac_start && !bus.flush)
        pend.push_back(bus.mac_sub ? (~bus.mul_result) + 64'd1 : bus.mul_result);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b1, 1'b0, 64'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Reset held two cycles with mac_start high.
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq("rst_stall", {58'd0, bus.stall}, 64'd0);
      check_eq("rst_valid", {63'd0, bus.mac_valid}, 64'd0);
      check_eq("rst_hilo", {bus.mac_hi, bus.mac_lo}, 64'd0);
      step();
    end
    rst = 1'b0;

    // MADD: 0:5 + 3 = 8.
    set_in(1'b1, 1'b0, 64'h3, 32'd0, 32'd5, 1'b0, 1'b0, 1'b0);
    settle(); check_eq("madd_c1_stall", {58'd0, bus.stall}, 64'h0f); step();
    settle();
    check_eq("madd_c2_valid", {63'd0, bus.mac_valid}, 64'd1);
    check_eq("madd_c2_res", {bus.mac_hi, bus.mac_lo}, 64'h8);
    check_eq("madd_c2_stall", {58'd0, bus.stall}, 64'd0);
    step();
    set_in(1'b0, 1'b0, 64'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    settle(); step();

    // MSUB with wrap: 0:1 - 2 = all ones.
    set_in(1'b1, 1'b1, 64'h2, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
    settle(); step();
    settle();
    check_eq("msub_res", {bus.mac_hi, bus.mac_lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    step();

    // Stall priority.
    set_in(1'b0, 1'b0, 64'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    settle(); check_eq("prio_ex_id", {58'd0, bus.stall}, 64'h0f); step();
    set_in(1'b0, 1'b0, 64'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    settle(); check_eq("prio_id", {58'd0, bus.stall}, 64'h07); step();
    set_in(1'b0, 1'b0, 64'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    settle(); check_eq("prio_flush", {58'd0, bus.stall}, 64'h00); step();

    // Flush while in ACC.
    set_in(1'b1, 1'b0, 64'h77, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
    settle(); step();
    bus.flush = 1'b1;
    settle(); check_eq("flush_t1_valid", {63'd0, bus.mac_valid}, 64'd0); step();
    set_in(1'b0, 1'b0, 64'h77, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
    settle();
    check_eq("flush_t2_stall", {58'd0, bus.stall}, 64'd0);
    check_eq("flush_t2_valid", {63'd0, bus.mac_valid}, 64'd0);
    step();

    // Back-to-back MACs, mac_start held four cycles.
    set_in(1'b1, 1'b0, 64'h10, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    settle(); check_eq("b2b_c0_stall", {58'd0, bus.stall}, 64'h0f); step();
    settle();
    check_eq("b2b_c1_valid", {63'd0, bus.mac_valid}, 64'd1);
    check_eq("b2b_c1_res", {bus.mac_hi, bus.mac_lo}, 64'h0000_0001_0000_0012);
    check_eq("b2b_c1_stall", {58'd0, bus.stall}, 64'h00);
    step();
    bus.mac_sub = 1'b1; bus.mul_result = 64'h5;
    settle();
    check_eq("b2b_c2_stall", {58'd0, bus.stall}, 64'h0f);
    check_eq("b2b_c2_valid", {63'd0, bus.mac_valid}, 64'd0);
    step();
    settle();
    check_eq("b2b_c3_valid", {63'd0, bus.mac_valid}, 64'd1);
    check_eq("b2b_c3_res", {bus.mac_hi, bus.mac_lo}, 64'h0000_0000_FFFF_FFFD);
    step();

    // External EX stall during ACC still yields the result.
    set_in(1'b1, 1'b0, 64'h9, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
    settle(); step();
    bus.stallreq_ex_ext = 1'b1;
    settle();
    check_eq("ext_acc_valid", {63'd0, bus.mac_valid}, 64'd1);
    check_eq("ext_acc_res", {bus.mac_hi, bus.mac_lo}, 64'hA);
    step();

    // Reset landing in ACC suppresses the result.
    set_in(1'b1, 1'b0, 64'h9, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
    settle(); step();
    rst = 1'b1;
    settle(); check_eq("rst_acc_valid", {63'd0, bus.mac_valid}, 64'd0); step();
    rst = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(99) < 2);
      set_in($urandom_range(99) < 55, $urandom_range(1) == 1,
             {$urandom, $urandom}, $urandom, $urandom,
             $urandom_range(99) < 8, $urandom_range(99) < 25,
             $urandom_range(99) < 15);
      settle();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
